// File: rtl/occupancy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : occupancy_pkg
// Description : Shared defaults and direction-FSM state encoding for the
//               occupancy light counter.
// Revision    : 1.0 - initial release
// ============================================================================
package occupancy_pkg;

  localparam int c_default_debounce_cycles = 4;
  localparam int c_default_timeout_cycles  = 1000;
  localparam int c_default_max_count       = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_A     = 3'd1,
    ST_IN_AB    = 3'd2,
    ST_IN_B     = 3'd3,
    ST_OUT_B    = 3'd4,
    ST_OUT_AB   = 3'd5,
    ST_OUT_A    = 3'd6,
    ST_WAIT_CLR = 3'd7
  } state_t;

endpackage : occupancy_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser followed by a stable-sample debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic debounced
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync_meta;
  logic               r_sync;
  logic               r_db;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= sensor_raw;
      r_sync      <= r_sync_meta;
    end
  end

  // Any sample matching the current output restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_db  <= r_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign debounced = r_db;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/occupancy_light_counter.sv
`default_nettype none
// ============================================================================
// Module      : occupancy_light_counter
// Description : Doorway passage classifier and saturating room occupancy
//               count driving the light-state decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module occupancy_light_counter
  import occupancy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
  parameter int TIMEOUT_CYCLES  = c_default_timeout_cycles,
  parameter int MAX_COUNT       = c_default_max_count
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       clear,
  output logic [3:0] active_lights,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       full,
  output logic       empty
);

  localparam int c_tmo_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         c_max      = 4'(MAX_COUNT);

  logic               w_db_a;
  logic               w_db_b;
  logic [1:0]         w_ab;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_tmo_w-1:0] r_tmo;
  logic               w_active;
  logic               w_timeout;
  logic               w_enter;
  logic               w_exit;
  logic [3:0]         r_count;
  logic               r_enter_pulse;
  logic               r_exit_pulse;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_a),
    .debounced (w_db_a)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk       (clk),
    .rst       (rst),
    .sensor_raw(sensor_b),
    .debounced (w_db_b)
  );

  assign w_ab      = {w_db_a, w_db_b};
  assign w_active  = (r_state != ST_IDLE) && (r_state != ST_WAIT_CLR);
  assign w_timeout = w_active && (r_tmo == c_tmo_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout wins over a completion in the same cycle, so it is tested first.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_WAIT_CLR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          case (w_ab)
            2'b10:   w_state_nxt = ST_IN_A;
            2'b01:   w_state_nxt = ST_OUT_B;
            2'b11:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_IDLE;
          endcase
        end
        ST_IN_A: begin
          case (w_ab)
            2'b11:   w_state_nxt = ST_IN_AB;
            2'b00:   w_state_nxt = ST_IDLE;
            2'b01:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_IN_A;
          endcase
        end
        ST_IN_AB: begin
          case (w_ab)
            2'b01:   w_state_nxt = ST_IN_B;
            2'b10:   w_state_nxt = ST_IN_A;
            2'b00:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_IN_AB;
          endcase
        end
        ST_IN_B: begin
          case (w_ab)
            2'b00: begin
              w_state_nxt = ST_IDLE;
              w_enter     = 1'b1;
            end
            2'b11:   w_state_nxt = ST_IN_AB;
            2'b10:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_IN_B;
          endcase
        end
        ST_OUT_B: begin
          case (w_ab)
            2'b11:   w_state_nxt = ST_OUT_AB;
            2'b00:   w_state_nxt = ST_IDLE;
            2'b10:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_OUT_B;
          endcase
        end
        ST_OUT_AB: begin
          case (w_ab)
            2'b10:   w_state_nxt = ST_OUT_A;
            2'b01:   w_state_nxt = ST_OUT_B;
            2'b00:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_OUT_AB;
          endcase
        end
        ST_OUT_A: begin
          case (w_ab)
            2'b00: begin
              w_state_nxt = ST_IDLE;
              w_exit      = 1'b1;
            end
            2'b11:   w_state_nxt = ST_OUT_AB;
            2'b01:   w_state_nxt = ST_WAIT_CLR;
            default: w_state_nxt = ST_OUT_A;
          endcase
        end
        ST_WAIT_CLR: begin
          if (w_ab == 2'b00) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Held at zero outside a live passage so every passage starts a fresh budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (!w_active || (w_state_nxt == ST_IDLE)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + c_tmo_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= 4'd0;
      r_enter_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
    end else begin
      r_enter_pulse <= w_enter;
      r_exit_pulse  <= w_exit;
      if (clear) begin
        r_count <= 4'd0;
      end else if (w_enter && (r_count != c_max)) begin
        r_count <= r_count + 4'd1;
      end else if (w_exit && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  assign active_lights = r_count;
  assign enter_pulse   = r_enter_pulse;
  assign exit_pulse    = r_exit_pulse;
  assign full          = (r_count == c_max);
  assign empty         = (r_count == 4'd0);

endmodule : occupancy_light_counter
`default_nettype wire

// File: tb/tb_occupancy_light_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_occupancy_light_counter
// Description : Directed self-checking bench for occupancy_light_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_occupancy_light_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_a;
  logic       sensor_b;
  logic       clear;
  logic [3:0] active_lights;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       full;
  logic       empty;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_enter = 0;
  int n_exit  = 0;

  always #5 clk = ~clk;

  occupancy_light_counter dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .clear        (clear),
    .active_lights(active_lights),
    .enter_pulse  (enter_pulse),
    .exit_pulse   (exit_pulse),
    .full         (full),
    .empty        (empty)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (enter_pulse) n_enter++;
      if (exit_pulse)  n_exit++;
    end
  end

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_enter();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic do_exit();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic test_reset();
    int e0, x0;
    rst = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e0 = n_enter; x0 = n_exit;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++; if (active_lights !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", active_lights); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if ((n_enter - e0) != 0 || (n_exit - x0) != 0) begin
      n_fail++; $display("FAIL reset_pulses got enter=%0d exit=%0d exp 0/0", n_enter - e0, n_exit - x0);
    end
  endtask

  task automatic test_entry();
    int e0;
    e0 = n_enter;
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd1) begin n_fail++; $display("FAIL entry1_count got=%0d exp=1", active_lights); end
    n_cmp++; if ((n_enter - e0) != 1) begin n_fail++; $display("FAIL entry1_pulses got=%0d exp=1", n_enter - e0); end
    do_enter();
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd3) begin n_fail++; $display("FAIL entry3_count got=%0d exp=3", active_lights); end
    n_cmp++; if ((n_enter - e0) != 3) begin n_fail++; $display("FAIL entry3_pulses got=%0d exp=3", n_enter - e0); end
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL entry3_empty got=%b exp=0", empty); end
  endtask

  task automatic test_exit();
    int e0, x0;
    e0 = n_enter; x0 = n_exit;
    do_exit();
    #1;
    n_cmp++; if (active_lights !== 4'd2) begin n_fail++; $display("FAIL exit_count got=%0d exp=2", active_lights); end
    n_cmp++; if ((n_exit - x0) != 1 || (n_enter - e0) != 0) begin
      n_fail++; $display("FAIL exit_pulses got exit=%0d enter=%0d exp 1/0", n_exit - x0, n_enter - e0);
    end
  endtask

  task automatic test_glitch();
    int e0, x0;
    e0 = n_enter; x0 = n_exit;
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 20);
    #1;
    n_cmp++; if ((n_enter - e0) != 0 || (n_exit - x0) != 0) begin
      n_fail++; $display("FAIL glitch_pulses got enter=%0d exit=%0d exp 0/0", n_enter - e0, n_exit - x0);
    end
    n_cmp++; if (active_lights !== 4'd2) begin n_fail++; $display("FAIL glitch_count got=%0d exp=2", active_lights); end
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd3) begin n_fail++; $display("FAIL glitch_then_entry got=%0d exp=3", active_lights); end
  endtask

  task automatic test_backout();
    int e0, x0;
    e0 = n_enter; x0 = n_exit;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    #1;
    n_cmp++; if ((n_enter - e0) != 0 || (n_exit - x0) != 0) begin
      n_fail++; $display("FAIL backout_pulses got enter=%0d exit=%0d exp 0/0", n_enter - e0, n_exit - x0);
    end
    n_cmp++; if (active_lights !== 4'd3) begin n_fail++; $display("FAIL backout_count got=%0d exp=3", active_lights); end
  endtask

  // Raw 00 lands in the debounced view after six edges; the FSM completes on the seventh.
  task automatic test_clear_collision();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    sensor_a = 1'b0; sensor_b = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (enter_pulse !== 1'b0 || active_lights !== 4'd3) begin
      n_fail++; $display("FAIL clr_pre got pulse=%b count=%0d exp 0/3", enter_pulse, active_lights);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_cmp++; if (enter_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_pulse got=%b exp=1", enter_pulse); end
    n_cmp++; if (active_lights !== 4'd0) begin n_fail++; $display("FAIL clr_count got=%0d exp=0", active_lights); end
    @(negedge clk);
    #1;
    n_cmp++; if (enter_pulse !== 1'b0 || active_lights !== 4'd0) begin
      n_fail++; $display("FAIL clr_post got pulse=%b count=%0d exp 0/0", enter_pulse, active_lights);
    end
  endtask

  task automatic test_saturate();
    int e0;
    e0 = n_enter;
    for (int i = 0; i < 16; i++) do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd15) begin n_fail++; $display("FAIL sat_count got=%0d exp=15", active_lights); end
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL sat_flags got full=%b empty=%b exp 1/0", full, empty); end
    n_cmp++; if ((n_enter - e0) != 16) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=16", n_enter - e0); end
  endtask

  task automatic test_exit_at_zero();
    int x0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_cmp++; if (active_lights !== 4'd0 || full !== 1'b0) begin
      n_fail++; $display("FAIL plain_clear got count=%0d full=%b exp 0/0", active_lights, full);
    end
    x0 = n_exit;
    do_exit();
    #1;
    n_cmp++; if (active_lights !== 4'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL zero_exit_count got count=%0d empty=%b exp 0/1", active_lights, empty);
    end
    n_cmp++; if ((n_exit - x0) != 1) begin n_fail++; $display("FAIL zero_exit_pulse got=%0d exp=1", n_exit - x0); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_enter;
    hold(1'b1, 1'b0, 1200);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    #1;
    n_cmp++; if ((n_enter - e0) != 0 || active_lights !== 4'd0) begin
      n_fail++; $display("FAIL timeout_nocount got pulses=%0d count=%0d exp 0/0", n_enter - e0, active_lights);
    end
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd1 || (n_enter - e0) != 1) begin
      n_fail++; $display("FAIL timeout_recover got count=%0d pulses=%0d exp 1/1", active_lights, n_enter - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0, x0;
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd2) begin n_fail++; $display("FAIL rmid_pre got=%0d exp=2", active_lights); end
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    rst = 1'b1;
    #1;
    n_cmp++; if (active_lights !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs got count=%0d empty=%b full=%b exp 0/1/0", active_lights, empty, full);
    end
    n_cmp++; if (enter_pulse !== 1'b0 || exit_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rmid_pulses got enter=%b exit=%b exp 0/0", enter_pulse, exit_pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    e0 = n_enter; x0 = n_exit;
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    #1;
    n_cmp++; if ((n_enter - e0) != 0 || (n_exit - x0) != 0 || active_lights !== 4'd0) begin
      n_fail++; $display("FAIL rmid_discard got enter=%0d exit=%0d count=%0d exp 0/0/0", n_enter - e0, n_exit - x0, active_lights);
    end
    do_enter();
    #1;
    n_cmp++; if (active_lights !== 4'd1) begin n_fail++; $display("FAIL rmid_recover got=%0d exp=1", active_lights); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_glitch();
    test_backout();
    test_clear_collision();
    test_saturate();
    test_exit_at_zero();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_occupancy_light_counter
`default_nettype wire
